// File: rtl/dma_pkg.sv
// rtl/dma_pkg.sv - shared register offsets, bit indices and FSM states for the byte DMA
package dma_pkg;

  localparam logic [2:0] REG_SRC_H  = 3'd0;
  localparam logic [2:0] REG_SRC_L  = 3'd1;
  localparam logic [2:0] REG_DST_H  = 3'd2;
  localparam logic [2:0] REG_DST_L  = 3'd3;
  localparam logic [2:0] REG_CNT_H  = 3'd4;
  localparam logic [2:0] REG_CNT_L  = 3'd5;
  localparam logic [2:0] REG_CTRL   = 3'd6;
  localparam logic [2:0] REG_STATUS = 3'd7;

  localparam int CTRL_START   = 0;
  localparam int CTRL_IRQ_EN  = 1;
  localparam int CTRL_SRC_FIX = 2;
  localparam int CTRL_DST_FIX = 3;
  localparam int CTRL_ABORT   = 7;

  localparam int ST_BUSY    = 0;
  localparam int ST_DONE    = 1;
  localparam int ST_ABORTED = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_RD,
    S_RDW,
    S_WR,
    S_NEXT,
    S_DONE
  } dma_state_t;

endpackage

// File: rtl/dma_regs.sv
// rtl/dma_regs.sv - CPU slave window: control/status flags, read mux, start/abort pulses
module dma_regs
  import dma_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  AD,
  input  logic [7:0]  DI,
  output logic [7:0]  DO,
  input  logic        rw,
  input  logic        cs,
  input  logic        busy,
  input  logic        done_set,
  input  logic        abort_set,
  input  logic [15:0] src,
  input  logic [15:0] dst,
  input  logic [15:0] cnt,
  output logic        ptr_wr,
  output logic        start,
  output logic        abort,
  output logic        src_fix,
  output logic        dst_fix,
  output logic        irq
);

  logic       wr;
  logic       ctrl_wr;
  logic       stat_rd;
  logic       irq_en;
  logic       irq_en_nxt;
  logic       done;
  logic       done_nxt;
  logic       aborted;
  logic       aborted_nxt;
  logic [7:0] rd_data;

  assign wr      = cs && !rw;
  assign ctrl_wr = wr && (AD == REG_CTRL) && !busy;
  assign stat_rd = cs && rw && (AD == REG_STATUS);
  assign ptr_wr  = wr && !busy && (AD <= REG_CNT_L);
  assign start   = ctrl_wr && DI[CTRL_START];
  assign abort   = wr && (AD == REG_CTRL) && DI[CTRL_ABORT] && busy;

  // a status read clears the sticky flags, but a same-cycle set takes priority
  assign done_nxt    = done_set  | (done    & ~stat_rd);
  assign aborted_nxt = abort_set | (aborted & ~stat_rd);
  assign irq_en_nxt  = ctrl_wr ? DI[CTRL_IRQ_EN] : irq_en;

  // CPU read mux; pointers and count are read live
  always_comb begin
    rd_data = 8'h00;
    case (AD)
      REG_SRC_H:  rd_data = src[15:8];
      REG_SRC_L:  rd_data = src[7:0];
      REG_DST_H:  rd_data = dst[15:8];
      REG_DST_L:  rd_data = dst[7:0];
      REG_CNT_H:  rd_data = cnt[15:8];
      REG_CNT_L:  rd_data = cnt[7:0];
      REG_CTRL:   rd_data = {4'b0000, dst_fix, src_fix, irq_en, 1'b0};
      REG_STATUS: rd_data = {5'b00000, aborted, done, busy};
      default:    rd_data = 8'h00;
    endcase
  end

  // control bits, sticky status flags, registered irq and read data
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_en  <= 1'b0;
      src_fix <= 1'b0;
      dst_fix <= 1'b0;
      done    <= 1'b0;
      aborted <= 1'b0;
      irq     <= 1'b0;
      DO      <= 8'h00;
    end else begin
      if (ctrl_wr) begin
        src_fix <= DI[CTRL_SRC_FIX];
        dst_fix <= DI[CTRL_DST_FIX];
      end
      irq_en  <= irq_en_nxt;
      done    <= done_nxt;
      aborted <= aborted_nxt;
      irq     <= done_nxt & irq_en_nxt;
      if (cs && rw) DO <= rd_data;
    end
  end

endmodule

// File: rtl/dmaio.sv
// rtl/dmaio.sv - memory-to-memory byte DMA master with bus request/grant and burst fairness
module dmaio
  import dma_pkg::*;
#(
  parameter int BURST_LEN = 16,
  parameter int ADDR_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        AD,
  input  logic [7:0]        DI,
  output logic [7:0]        DO,
  input  logic              rw,
  input  logic              cs,
  output logic              irq,
  output logic              breq,
  input  logic              bgnt,
  output logic [ADDR_W-1:0] m_ad,
  output logic [7:0]        m_do,
  input  logic [7:0]        m_di,
  output logic              m_rw,
  output logic              m_vma
);

  dma_state_t        state, state_nxt;
  logic [ADDR_W-1:0] src, dst;
  logic [15:0]       cnt;
  logic [7:0]        burst;
  logic [7:0]        data;
  logic              abort_pend;
  logic              busy, vma_i, done_set, abort_set;
  logic              ptr_wr, start, abort, src_fix, dst_fix;
  logic [15:0]       src16, dst16;

  assign src16 = 16'(src);
  assign dst16 = 16'(dst);
  assign busy  = (state != S_IDLE) && (state != S_DONE);
  assign m_vma = vma_i & breq & bgnt;

  dma_regs u_regs (
    .clk       (clk),
    .rst       (rst),
    .AD        (AD),
    .DI        (DI),
    .DO        (DO),
    .rw        (rw),
    .cs        (cs),
    .busy      (busy),
    .done_set  (done_set),
    .abort_set (abort_set),
    .src       (src16),
    .dst       (dst16),
    .cnt       (cnt),
    .ptr_wr    (ptr_wr),
    .start     (start),
    .abort     (abort),
    .src_fix   (src_fix),
    .dst_fix   (dst_fix),
    .irq       (irq)
  );

  // next-state and master bus outputs
  always_comb begin
    state_nxt = state;
    breq      = 1'b0;
    vma_i     = 1'b0;
    m_rw      = 1'b1;
    m_ad      = '0;
    m_do      = 8'h00;
    done_set  = 1'b0;
    abort_set = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (cnt != 16'd0) state_nxt = S_REQ;
          else              done_set  = 1'b1;
        end
      end
      S_REQ: begin
        breq = 1'b1;
        if (bgnt) state_nxt = S_RD;
      end
      S_RD: begin
        breq      = 1'b1;
        vma_i     = 1'b1;
        m_ad      = src;
        state_nxt = S_RDW;
      end
      S_RDW: begin
        breq      = 1'b1;
        state_nxt = S_WR;
      end
      S_WR: begin
        breq      = 1'b1;
        vma_i     = 1'b1;
        m_rw      = 1'b0;
        m_ad      = dst;
        m_do      = data;
        state_nxt = S_NEXT;
      end
      S_NEXT: begin
        breq = 1'b1;
        if (cnt == 16'd0) begin
          state_nxt = S_DONE;
        end else if (abort_pend) begin
          abort_set = 1'b1;
          state_nxt = S_DONE;
        end else if (burst == 8'd0) begin
          breq      = 1'b0;
          state_nxt = S_REQ;
        end else begin
          state_nxt = S_RD;
        end
      end
      S_DONE: begin
        done_set  = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // state register, pointers, count, burst budget and data latch
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      src        <= '0;
      dst        <= '0;
      cnt        <= 16'd0;
      burst      <= 8'd0;
      data       <= 8'h00;
      abort_pend <= 1'b0;
    end else begin
      state <= state_nxt;
      if (ptr_wr) begin
        case (AD)
          REG_SRC_H: src <= ADDR_W'({DI, src16[7:0]});
          REG_SRC_L: src <= ADDR_W'({src16[15:8], DI});
          REG_DST_H: dst <= ADDR_W'({DI, dst16[7:0]});
          REG_DST_L: dst <= ADDR_W'({dst16[15:8], DI});
          REG_CNT_H: cnt <= {DI, cnt[7:0]};
          REG_CNT_L: cnt <= {cnt[15:8], DI};
          default: ;
        endcase
      end
      if (state == S_IDLE && start) burst <= 8'(BURST_LEN);
      if (state == S_RDW) data <= m_di;
      if (state == S_WR) begin
        src   <= src + {{(ADDR_W-1){1'b0}}, ~src_fix};
        dst   <= dst + {{(ADDR_W-1){1'b0}}, ~dst_fix};
        cnt   <= cnt - 16'd1;
        burst <= burst - 8'd1;
      end
      if (state == S_NEXT && burst == 8'd0) burst <= 8'(BURST_LEN);
      if (abort) abort_pend <= 1'b1;
      if (state == S_DONE || state == S_IDLE) abort_pend <= 1'b0;
    end
  end

endmodule
